// File: rtl/result_serializer_pkg.sv
// Shared constants and FSM state type for the result serializer.
package result_serializer_pkg;

    localparam int unsigned LANE_W = 32;
    localparam int unsigned ADDR_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

endpackage

// File: rtl/result_serializer_row_fifo.sv
// Row FIFO: wrapping read/write pointers plus an occupancy count.
// A pop never frees a slot for a same-edge push while full.
module row_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset,   // active-low, asynchronous
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [WIDTH-1:0]       i_wdata,
    output logic [WIDTH-1:0]       o_rdata,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rptr];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointer and count update; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/result_serializer.sv
// Result serializer: queues accumulator rows and emits them one 32-bit lane
// per handshake, lane 0 first, with out_last on the final lane.
// Optional feature: define RESULT_RELU_EN to clamp negative lanes to zero.
module result_serializer
    import result_serializer_pkg::*;
#(
    parameter int unsigned ARR_SIZE = 4,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                       i_clk,
    input  logic                       i_reset,   // active-low, asynchronous
    input  logic                       i_row_valid,
    input  logic [ARR_SIZE*LANE_W-1:0] i_row_data,
    input  logic [ADDR_W-1:0]          i_row_addr,
    output logic                       o_row_ready,
    output logic                       o_out_valid,
    output logic [LANE_W-1:0]          o_out_data,
    output logic [ADDR_W-1:0]          o_out_addr,
    output logic                       o_out_last,
    input  logic                       i_out_ready,
    output logic                       o_fifo_full,
    output logic                       o_fifo_empty
);

    localparam int unsigned ROW_W = ARR_SIZE * LANE_W;
    localparam int unsigned ENT_W = ROW_W + ADDR_W;
    localparam int unsigned LW    = (ARR_SIZE > 1) ? $clog2(ARR_SIZE) : 1;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    state_e              r_state;
    state_e              w_state_next;
    logic [ROW_W-1:0]    r_shift;     // lanes still to be sent, next lane in low bits
    logic [LW-1:0]       r_lane;
    logic                r_out_valid;
    logic [LANE_W-1:0]   r_out_data;
    logic [ADDR_W-1:0]   r_out_addr;
    logic                r_out_last;

    logic [ENT_W-1:0]    w_head;
    logic [ROW_W-1:0]    w_head_row;
    logic [ADDR_W-1:0]   w_head_addr;
    logic                w_full;
    logic                w_empty;
    logic [CW-1:0]       w_count;
    logic                w_pop;
    logic                w_adv;
    logic                w_at_last;

    function automatic logic [LANE_W-1:0] lane_xform(input logic [LANE_W-1:0] v);
`ifdef RESULT_RELU_EN
        return v[LANE_W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    row_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_row_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (i_row_valid),
        .i_pop   (w_pop),
        .i_wdata ({i_row_addr, i_row_data}),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_head_row   = w_head[ROW_W-1:0];
    assign w_head_addr  = w_head[ENT_W-1 -: ADDR_W];
    assign w_at_last    = (r_lane == LW'(ARR_SIZE - 1));
    assign o_row_ready  = (w_count < CW'(DEPTH));
    assign o_fifo_full  = w_full;
    assign o_fifo_empty = w_empty;
    assign o_out_valid  = r_out_valid;
    assign o_out_data   = r_out_data;
    assign o_out_addr   = r_out_addr;
    assign o_out_last   = r_out_last;

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, pop and lane-advance decode; next row loads on the last
    // handshake so back-to-back rows have no bubble.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_adv        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = SEND;
                end
            end
            SEND: begin
                if (i_out_ready) begin
                    if (w_at_last) begin
                        if (!w_empty) begin
                            w_pop = 1'b1;
                        end else begin
                            w_state_next = IDLE;
                        end
                    end else begin
                        w_adv = 1'b1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Output word registers and lane shift register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_shift     <= '0;
            r_lane      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_pop) begin
            r_shift     <= w_head_row >> LANE_W;
            r_lane      <= '0;
            r_out_valid <= 1'b1;
            r_out_data  <= lane_xform(w_head_row[LANE_W-1:0]);
            r_out_addr  <= w_head_addr;
            r_out_last  <= (ARR_SIZE == 1);
        end else if (w_adv) begin
            r_shift     <= r_shift >> LANE_W;
            r_lane      <= r_lane + LW'(1);
            r_out_data  <= lane_xform(r_shift[LANE_W-1:0]);
            r_out_last  <= (r_lane == LW'(ARR_SIZE - 2));
        end else if (r_state == SEND && w_state_next == IDLE) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_result_serializer.sv
// Directed testbench for result_serializer (ARR_SIZE=4, DEPTH=4).
module tb_result_serializer;

    logic         clk;
    logic         reset_n;
    logic         row_valid;
    logic [127:0] row_data;
    logic [3:0]   row_addr;
    logic         row_ready;
    logic         out_valid;
    logic [31:0]  out_data;
    logic [3:0]   out_addr;
    logic         out_last;
    logic         out_ready;
    logic         fifo_full;
    logic         fifo_empty;

    int n_tests = 0;
    int n_fail  = 0;

    result_serializer #(
        .ARR_SIZE (4),
        .DEPTH    (4)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset_n),
        .i_row_valid  (row_valid),
        .i_row_data   (row_data),
        .i_row_addr   (row_addr),
        .o_row_ready  (row_ready),
        .o_out_valid  (out_valid),
        .o_out_data   (out_data),
        .o_out_addr   (out_addr),
        .o_out_last   (out_last),
        .i_out_ready  (out_ready),
        .o_fifo_full  (fifo_full),
        .o_fifo_empty (fifo_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Row r lane l carries r*16+l.
    function automatic logic [127:0] mk_row(input int r);
        logic [127:0] v;
        for (int l = 0; l < 4; l++) v[32*l +: 32] = 32'(r * 16 + l);
        return v;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; row_valid = 1'b0; row_data = '0; row_addr = '0; out_ready = 1'b0;
        tick(); tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_tests++; if (out_data !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", out_data); end
        n_tests++; if (out_addr !== 4'd0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", out_addr); end
        n_tests++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", out_last); end
        n_tests++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", fifo_empty); end
        n_tests++; if (fifo_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", fifo_full); end
        n_tests++; if (row_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", row_ready); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single_row();
        logic [31:0] exp_w [4];
        exp_w[0] = 32'd1; exp_w[1] = 32'd2; exp_w[2] = 32'd3; exp_w[3] = 32'd4;
        out_ready = 1'b1;
        row_valid = 1'b1; row_data = {32'd4, 32'd3, 32'd2, 32'd1}; row_addr = 4'd5;
        tick();  // acceptance edge
        row_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early: got %b want 0", out_valid); end
        n_tests++; if (fifo_empty !== 1'b0) begin n_fail++; $display("FAIL single_queued: got %b want 0", fifo_empty); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid%0d: got %b want 1", i, out_valid); end
            n_tests++; if (out_data !== exp_w[i]) begin n_fail++; $display("FAIL single_data%0d: got %h want %h", i, out_data, exp_w[i]); end
            n_tests++; if (out_addr !== 4'd5) begin n_fail++; $display("FAIL single_addr%0d: got %h want 5", i, out_addr); end
            n_tests++; if (out_last !== (i == 3)) begin n_fail++; $display("FAIL single_last%0d: got %b want %b", i, out_last, (i == 3)); end
        end
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %b want 0", out_valid); end
        n_tests++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL single_drained: got %b want 1", fifo_empty); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        row_valid = 1'b1; row_data = {32'd4, 32'd3, 32'd2, 32'd1}; row_addr = 4'd3;
        tick();
        row_valid = 1'b0;
        tick();  // lane 0 shown
        n_tests++; if (out_data !== 32'd1) begin n_fail++; $display("FAIL bp_lane0: got %h want 1", out_data); end
        tick();  // lane 1 shown
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (out_data !== 32'd2 || out_valid !== 1'b1 || out_last !== 1'b0 || out_addr !== 4'd3)
                begin n_fail++; $display("FAIL bp_hold%0d: got data %h valid %b last %b addr %h want 2 1 0 3", i, out_data, out_valid, out_last, out_addr); end
        end
        out_ready = 1'b1;
        tick();
        n_tests++; if (out_data !== 32'd3) begin n_fail++; $display("FAIL bp_lane2: got %h want 3", out_data); end
        tick();
        n_tests++; if (out_data !== 32'd4 || out_last !== 1'b1) begin n_fail++; $display("FAIL bp_lane3: got %h last %b want 4 1", out_data, out_last); end
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle: got %b want 0", out_valid); end
    endtask

    task automatic test_full_fifo();
        logic acc;
        out_ready = 1'b0;
        for (int r = 1; r <= 5; r++) begin
            row_valid = 1'b1; row_data = mk_row(r); row_addr = 4'(r);
            n_tests++; if (row_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_row%0d: got %b want 1", r, row_ready); end
            tick();
        end
        row_data = mk_row(6); row_addr = 4'd6;
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (fifo_full !== 1'b1 || row_ready !== 1'b0)
                begin n_fail++; $display("FAIL full_stall%0d: got full %b ready %b want 1 0", i, fifo_full, row_ready); end
            n_tests++; if (out_valid !== 1'b1 || out_data !== 32'd16 || out_addr !== 4'd1)
                begin n_fail++; $display("FAIL full_head%0d: got valid %b data %h addr %h want 1 10 1", i, out_valid, out_data, out_addr); end
            tick();
        end
        out_ready = 1'b1;
        for (int w = 0; w < 24; w++) begin
            int er;
            int el;
            er = w / 4 + 1;
            el = w % 4;
            n_tests++; if (out_valid !== 1'b1 || out_data !== 32'(er * 16 + el) || out_addr !== 4'(er) || out_last !== (el == 3))
                begin n_fail++; $display("FAIL full_drain%0d: got valid %b data %h addr %h last %b want 1 %h %h %b", w, out_valid, out_data, out_addr, out_last, 32'(er * 16 + el), 4'(er), (el == 3)); end
            acc = row_valid && row_ready;
            tick();
            if (acc) row_valid = 1'b0;
        end
        n_tests++; if (out_valid !== 1'b0 || fifo_empty !== 1'b1) begin n_fail++; $display("FAIL full_end: got valid %b empty %b want 0 1", out_valid, fifo_empty); end
    endtask

    task automatic test_push_pop();
        out_ready = 1'b0;
        for (int r = 1; r <= 3; r++) begin  // rows A=1, B=2, C=3
            row_valid = 1'b1; row_data = mk_row(r); row_addr = 4'(r);
            tick();
        end
        row_valid = 1'b0;
        n_tests++; if (dut.w_count !== 3'd2) begin n_fail++; $display("FAIL pp_count_pre: got %0d want 2", dut.w_count); end
        out_ready = 1'b1;
        tick(); tick(); tick();
        n_tests++; if (out_last !== 1'b1 || out_data !== 32'd19) begin n_fail++; $display("FAIL pp_a_last: got last %b data %h want 1 13", out_last, out_data); end
        row_valid = 1'b1; row_data = mk_row(4); row_addr = 4'd4;  // row D, pushed as B pops
        tick();
        row_valid = 1'b0;
        n_tests++; if (dut.w_count !== 3'd2) begin n_fail++; $display("FAIL pp_count_post: got %0d want 2", dut.w_count); end
        for (int w = 0; w < 12; w++) begin
            int er;
            er = w / 4 + 2;
            n_tests++; if (out_valid !== 1'b1 || out_data !== 32'(er * 16 + w % 4) || out_addr !== 4'(er))
                begin n_fail++; $display("FAIL pp_order%0d: got valid %b data %h addr %h want 1 %h %h", w, out_valid, out_data, out_addr, 32'(er * 16 + w % 4), 4'(er)); end
            tick();
        end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pp_idle: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_row();
        out_ready = 1'b1;
        row_valid = 1'b1; row_data = mk_row(7); row_addr = 4'd7;
        tick();
        row_data = mk_row(8); row_addr = 4'd8;
        tick();
        row_valid = 1'b0;
        tick(); tick();
        n_tests++; if (out_data !== 32'd114) begin n_fail++; $display("FAIL rst_lane2: got %h want 72", out_data); end
        reset_n = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0 || fifo_empty !== 1'b1 || out_data !== 32'd0 || row_ready !== 1'b1)
            begin n_fail++; $display("FAIL rst_async: got valid %b empty %b data %h ready %b want 0 1 0 1", out_valid, fifo_empty, out_data, row_ready); end
        tick();
        reset_n = 1'b1;
        tick(); tick();
        n_tests++; if (out_valid !== 1'b0 || fifo_empty !== 1'b1) begin n_fail++; $display("FAIL rst_no_resume: got valid %b empty %b want 0 1", out_valid, fifo_empty); end
        row_valid = 1'b1; row_data = mk_row(9); row_addr = 4'd9;
        tick();
        row_valid = 1'b0;
        for (int l = 0; l < 4; l++) begin
            tick();
            n_tests++; if (out_valid !== 1'b1 || out_data !== 32'(144 + l) || out_addr !== 4'd9 || out_last !== (l == 3))
                begin n_fail++; $display("FAIL rst_new%0d: got valid %b data %h addr %h last %b want 1 %h 9 %b", l, out_valid, out_data, out_addr, out_last, 32'(144 + l), (l == 3)); end
        end
        tick();
    endtask

    task automatic test_relu();
        logic [31:0] exp_w [4];
`ifdef RESULT_RELU_EN
        exp_w[0] = 32'd0; exp_w[1] = 32'd9; exp_w[2] = 32'd0; exp_w[3] = 32'd0;
`else
        exp_w[0] = 32'hFFFF_FFF9; exp_w[1] = 32'd9; exp_w[2] = 32'h8000_0000; exp_w[3] = 32'd0;
`endif
        out_ready = 1'b1;
        row_valid = 1'b1; row_data = {32'd0, 32'h8000_0000, 32'd9, 32'hFFFF_FFF9}; row_addr = 4'd2;
        tick();
        row_valid = 1'b0;
        for (int l = 0; l < 4; l++) begin
            tick();
            n_tests++; if (out_valid !== 1'b1 || out_data !== exp_w[l])
                begin n_fail++; $display("FAIL relu_lane%0d: got valid %b data %h want 1 %h", l, out_valid, out_data, exp_w[l]); end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_backpressure();
        test_full_fifo();
        test_push_pop();
        test_reset_mid_row();
        test_relu();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
